// File: rtl/ram_pkg.sv
// Shared types and defaults for the RAM burst read path.
package ram_pkg;

  localparam int RAM_WIDTH     = 8;
  localparam int RAM_DEPTH     = 16;
  localparam int RD_FIFO_SLOTS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Three-entry ring buffer holding read words (data plus last flag) on their way to the stream port.
module ram_rd_fifo import ram_pkg::*; #(
  parameter int ENTRY_WIDTH = RAM_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [ENTRY_WIDTH-1:0] push_data,
  input  logic                   pop,
  output logic [ENTRY_WIDTH-1:0] head,
  output logic                   empty,
  output logic [1:0]             count
);

  logic [ENTRY_WIDTH-1:0] mem [RD_FIFO_SLOTS];
  logic [1:0]             rd_ptr;
  logic [1:0]             wr_ptr;
  logic [1:0]             count_q;
  logic                   push_ok;
  logic                   pop_ok;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Writes are refused only when full; the issuer's credit check keeps that from happening.
  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && (count_q != 2'd3);
  end

  // Storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= 2'd0;
      wr_ptr  <= 2'd0;
      count_q <= 2'd0;
      for (int i = 0; i < RD_FIFO_SLOTS; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head reads as zero while empty so the stream data port is quiet between words.
  always_comb begin
    empty = (count_q == 2'd0);
    count = count_q;
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator: issues sequential RAM reads and streams the words out with backpressure.
module ram_burst_reader import ram_pkg::*; #(
  parameter int WIDTH      = RAM_WIDTH,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [WIDTH-1:0]      ram_din,
  input  logic [WIDTH-1:0]      ram_dout
);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [LEN_WIDTH-1:0]  len_clamped;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic                  done_q;
  logic                  accept;
  logic                  credit;
  logic                  final_issue;
  logic                  pop;
  logic                  last_pop;
  logic [WIDTH:0]        fifo_head;
  logic                  fifo_empty;
  logic [1:0]            fifo_count;

  // Handshake, clamp and credit terms; credit uses only registered state so out_ready never reaches ram_re.
  always_comb begin
    accept      = cmd_valid && cmd_ready;
    len_clamped = (cmd_len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : cmd_len;
    credit      = (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'(RD_FIFO_SLOTS));
    final_issue = ram_re && (remaining_q == LEN_WIDTH'(1));
    pop         = out_valid && out_ready;
    last_pop    = pop && fifo_head[WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a zero-length command completes without leaving IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (len_clamped != '0)) state_next = RUN;
      RUN:     if (final_issue) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    ram_re    = (state == RUN) && credit;
  end

  // Address/remaining counters, in-flight tracking and the registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= cmd_addr;
        remaining_q <= len_clamped;
      end else if (ram_re) begin
        addr_q      <= addr_q + ADDR_WIDTH'(1);
        remaining_q <= remaining_q - LEN_WIDTH'(1);
      end
      inflight_q      <= ram_re;
      inflight_last_q <= final_issue;
      done_q          <= (accept && (len_clamped == '0)) || ((state == DRAIN) && last_pop);
    end
  end

  ram_rd_fifo #(
    .ENTRY_WIDTH(WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data({inflight_last_q, ram_dout}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Stream port and the read-only RAM side.
  always_comb begin
    out_valid = !fifo_empty;
    out_data  = fifo_head[WIDTH-1:0];
    out_last  = fifo_head[WIDTH];
    done      = done_q;
    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_din   = '0;
  end

endmodule
